lcd_status_display: RTL and testbench
=====================================

// Module: lcd_status_display
// PURPOSE
//  Drives the 16x2 HD44780-compatible character LCD with the recorder's live status: mode, transport state and play speed.
//  Sits downstream of the top-level control FSM; consumes its 3-bit state code and 4-bit play_speed code.
//  Owns LCD power-up, the init sequence, and change-triggered full-screen refresh. Write-only: it never reads the busy flag.
// PARAMETERS
//  T_PWRUP  750000  cycles idle after reset before the first command (15 ms @ 50 MHz)
//  T_EN     16      cycles LCD_EN is held high per byte
//  T_CMD    2500    post-byte wait, cycles, for every byte except clear (50 us)
//  T_CLR    82000   post-byte wait, cycles, after clear-display 0x01 (1.64 ms)
// PORTS
//  clk           in   1  system clock (50 MHz)
//  rst           in   1  synchronous reset, active-low
//  i_state       in   3  control FSM state: 101 INIT, 000/010/011 PLAY stop/play/pause, 100/110/111 RECORD stop/record/pause
//  i_play_speed  in   4  0000 x1; 1001..1111 x2..x8; 0001..0111 x1/2..x1/8; 1000 invalid
//  LCD_DATA      out  8  byte to LCD
//  LCD_EN        out  1  write strobe; data latched by the LCD on the falling edge
//  LCD_RS        out  1  0 command, 1 character
//  LCD_RW        out  1  tied 0
//  LCD_ON        out  1  tied 1
//  LCD_BLON      out  1  tied 1
//  o_busy        out  1  high whenever the top FSM is not in IDLE
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): top FSM->PWRUP, counters clear, LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, o_busy=1.
//    Reset mid-byte drops EN on the next edge. An aborted byte is never resumed.
//  - Byte-write sub-FSM, per byte:
//    * SETUP: 1 cycle, EN=0, RS/DATA valid.
//    * PULSE: T_EN cycles, EN=1.
//    * WAIT: T_CMD cycles (T_CLR if command 0x01), EN=0.
//    * RS/DATA stay stable from SETUP through the end of WAIT.
//    * Cost per byte: 1+T_EN+T_CMD cycles (1+T_EN+T_CLR for clear).
//  - Top FSM: PWRUP(T_PWRUP cycles) -> INIT -> REFRESH -> IDLE.
//    * INIT: commands 0x38, 0x0C, 0x01, 0x06 in order.
//    * REFRESH: 34 bytes in this order:
//      1. cmd 0x80
//      2. 16 chars for line 1
//      3. cmd 0xC0
//      4. 16 chars for line 2
//  - Snapshot: {i_state, i_play_speed} is registered into snap at REFRESH entry. All characters derive from snap only.
//  - IDLE: o_busy=0. If the live inputs != snap, go to REFRESH on the next edge.
//    * Inputs that change during a refresh do not alter it. The comparison after return to IDLE triggers one more refresh.
//    * Intermediate values may be skipped; only the latest value is ever shown.
//  - Line 1 (16 chars, space padded):
//    * "MODE: INIT" if snap state = 101
//    * else "MODE: PLAY" if state[2]=0
//    * else "MODE: RECORD"
//  - Line 2:
//    * Cols 0-4, word by state[1:0]: 00 "STOP ", 10 "PLAY " (or "REC  " if state[2]=1), 11 "PAUSE". INIT shows "-----".
//    * Cols 5-10: " SPD: ".
//    * Cols 11-15: speed text, left-aligned, space padded. x1..x8 as "x<n>", e.g. 1001 -> "x2". x1/n as "x1/<n>", e.g. 0111 -> "x1/8". 1000 -> "x?".
//    * RECORD modes and INIT always show "--" for speed, regardless of i_play_speed.
//  - Characters are ASCII, generated combinationally from snap and a column counter (0..15). No RAM.
//  - State codes not listed (001) render as INIT.
// TESTING (sim params: T_PWRUP=20, T_EN=2, T_CMD=4, T_CLR=8)
//  1. Reset released, i_state=101 -> EN=0 for 20+1 cycles; then EN pulses carry RS=0 bytes 38,0C,01,06.
//     Spacing 7 cycles between EN rises, 11 after 0x01.
//  2. Continue 1 -> 0x80, "MODE: INIT      ", 0xC0, "----- SPD: --   " (RS=1 for chars).
//     o_busy falls exactly 1 cycle after the last WAIT.
//  3. In IDLE, set state=010 and speed=1011 -> o_busy rises next edge. Line 2 reads "PLAY  SPD: x4   ".
//  4. Mid-refresh, change speed 0000->0111->0001 -> current refresh completes unchanged. Exactly one more refresh follows, showing "x1/2".
//  5. state=110, speed=1111 -> "MODE: RECORD", "REC   SPD: --   ".
//  6. Assert rst during a PULSE -> EN=0 on the next edge, o_busy=1. A full PWRUP/INIT sequence repeats.

Source files
------------

// File: rtl/lcd_status_display.sv
// HD44780 16x2 status display driver: power-up wait, init sequence and a full
// two-line refresh whenever the control FSM state or play speed changes.
module lcd_status_display #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_EN    = 16,
    parameter int unsigned T_CMD   = 2500,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_state,
    input  logic [3:0] i_play_speed,
    output logic [7:0] LCD_DATA,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       o_busy
);

    localparam int unsigned CntMaxA = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int unsigned CntMaxB = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int unsigned CntMax  = (CntMaxA > CntMaxB) ? CntMaxA : CntMaxB;
    localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] PwrupLast = CntW'(T_PWRUP - 1);
    localparam logic [CntW-1:0] EnLast    = CntW'(T_EN - 1);
    localparam logic [CntW-1:0] CmdLast   = CntW'(T_CMD - 1);
    localparam logic [CntW-1:0] ClrLast   = CntW'(T_CLR - 1);

    typedef enum logic [1:0] {StPwrup, StInit, StRefresh, StIdle} top_e;
    typedef enum logic [1:0] {BySetup, ByPulse, ByWait} by_e;

    top_e            top_q, top_d;
    by_e             by_st_q, by_st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [6:0]      snap_q, snap_d;

    logic [2:0]      snap_st;
    logic [3:0]      snap_sp;
    logic            is_init;
    logic            is_rec;
    logic [127:0]    line1;
    logic [127:0]    line2;
    logic [39:0]     word;
    logic [39:0]     spd;
    logic [3:0]      spd_n;
    logic [7:0]      spd_digit;
    logic [3:0]      col;
    logic            byte_rs;
    logic [7:0]      byte_data;
    logic [CntW-1:0] wait_last;
    logic [5:0]      last_idx;
    logic            active;

    assign snap_st = snap_q[6:4];
    assign snap_sp = snap_q[3:0];
    // 001 is not a real state code; it renders as INIT.
    assign is_init = (snap_st == 3'b101) || (snap_st == 3'b001);
    assign is_rec  = snap_st[2] && !is_init;

    always_comb begin
        spd_n     = 4'd0;
        spd_digit = 8'h30;
        spd       = "--   ";
        if (!is_init && !is_rec) begin
            if (snap_sp == 4'b0000) begin
                spd = "x1   ";
            end else if (snap_sp == 4'b1000) begin
                spd = "x?   ";
            end else if (snap_sp[3]) begin
                spd_n     = snap_sp - 4'd7;
                spd_digit = 8'h30 + {4'h0, spd_n};
                spd       = {"x", spd_digit, "   "};
            end else begin
                spd_n     = snap_sp + 4'd1;
                spd_digit = 8'h30 + {4'h0, spd_n};
                spd       = {"x1/", spd_digit, " "};
            end
        end
    end

    always_comb begin
        if (is_init) begin
            line1 = "MODE: INIT      ";
            word  = "-----";
        end else begin
            line1 = snap_st[2] ? "MODE: RECORD    " : "MODE: PLAY      ";
            case (snap_st[1:0])
                2'b00:   word = "STOP ";
                2'b10:   word = snap_st[2] ? "REC  " : "PLAY ";
                2'b11:   word = "PAUSE";
                default: word = "-----";
            endcase
        end
        line2 = {word, " SPD: ", spd};
    end

    // Refresh byte index: 0 = 0x80, 1..16 = line 1, 17 = 0xC0, 18..33 = line 2.
    assign col = (idx_q < 6'd17) ? (idx_q[3:0] - 4'd1) : (idx_q[3:0] - 4'd2);

    always_comb begin
        byte_rs   = 1'b0;
        byte_data = 8'h00;
        if (top_q == StInit) begin
            case (idx_q[1:0])
                2'd0:    byte_data = 8'h38;
                2'd1:    byte_data = 8'h0C;
                2'd2:    byte_data = 8'h01;
                default: byte_data = 8'h06;
            endcase
        end else if (top_q == StRefresh) begin
            if (idx_q == 6'd0) begin
                byte_data = 8'h80;
            end else if (idx_q == 6'd17) begin
                byte_data = 8'hC0;
            end else if (idx_q < 6'd17) begin
                byte_rs   = 1'b1;
                byte_data = line1[{~col, 3'b000} +: 8];
            end else begin
                byte_rs   = 1'b1;
                byte_data = line2[{~col, 3'b000} +: 8];
            end
        end
    end

    assign wait_last = (!byte_rs && byte_data == 8'h01) ? ClrLast : CmdLast;
    assign last_idx  = (top_q == StInit) ? 6'd3 : 6'd33;
    assign active    = (top_q == StInit) || (top_q == StRefresh);

    always_comb begin
        top_d   = top_q;
        by_st_d = by_st_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (top_q)
            StPwrup: begin
                if (cnt_q == PwrupLast) begin
                    top_d   = StInit;
                    by_st_d = BySetup;
                    cnt_d   = '0;
                    idx_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StInit, StRefresh: begin
                case (by_st_q)
                    BySetup: begin
                        by_st_d = ByPulse;
                        cnt_d   = '0;
                    end
                    ByPulse: begin
                        if (cnt_q == EnLast) begin
                            by_st_d = ByWait;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    ByWait: begin
                        if (cnt_q == wait_last) begin
                            by_st_d = BySetup;
                            cnt_d   = '0;
                            if (idx_q == last_idx) begin
                                idx_d = 6'd0;
                                if (top_q == StInit) begin
                                    top_d  = StRefresh;
                                    snap_d = {i_state, i_play_speed};
                                end else begin
                                    top_d = StIdle;
                                end
                            end else begin
                                idx_d = idx_q + 6'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        by_st_d = BySetup;
                        cnt_d   = '0;
                    end
                endcase
            end
            StIdle: begin
                if ({i_state, i_play_speed} != snap_q) begin
                    top_d   = StRefresh;
                    snap_d  = {i_state, i_play_speed};
                    by_st_d = BySetup;
                    cnt_d   = '0;
                    idx_d   = 6'd0;
                end
            end
            default: top_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            top_q   <= StPwrup;
            by_st_q <= BySetup;
            cnt_q   <= '0;
            idx_q   <= 6'd0;
            snap_q  <= 7'd0;
        end else begin
            top_q   <= top_d;
            by_st_q <= by_st_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    assign LCD_DATA = byte_data;
    assign LCD_RS   = byte_rs;
    assign LCD_EN   = active && (by_st_q == ByPulse);
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;
    assign o_busy   = (top_q != StIdle);

endmodule

// File: tb/tb_lcd_status_display.sv
// Bench for lcd_status_display: captures every LCD write and compares screens
// against a string-level model of what the display should read.
module tb_lcd_status_display;

    localparam int TPwrup  = 20;
    localparam int TEn     = 2;
    localparam int TCmd    = 4;
    localparam int TClr    = 8;
    localparam int ByteGap = 1 + TEn + TCmd;
    localparam int ClrGap  = 1 + TEn + TClr;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] i_state;
    logic [3:0] i_play_speed;
    logic [7:0] LCD_DATA;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_ON;
    logic       LCD_BLON;
    logic       o_busy;

    lcd_status_display #(
        .T_PWRUP(TPwrup),
        .T_EN   (TEn),
        .T_CMD  (TCmd),
        .T_CLR  (TClr)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_state     (i_state),
        .i_play_speed(i_play_speed),
        .LCD_DATA    (LCD_DATA),
        .LCD_EN      (LCD_EN),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_ON      (LCD_ON),
        .LCD_BLON    (LCD_BLON),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: one entry per EN rising edge, plus EN widths and busy falls.
    logic [8:0] byte_q[$];
    int         rise_q[$];
    int         width_q[$];
    int         fall_cyc = 0;
    int         en_len   = 0;
    logic       en_prev  = 1'b0;
    logic       busy_prev = 1'b0;

    always @(negedge clk) begin
        if (LCD_EN && !en_prev) begin
            byte_q.push_back({LCD_RS, LCD_DATA});
            rise_q.push_back(cyc);
        end
        if (LCD_EN) begin
            en_len <= en_len + 1;
        end else begin
            if (en_prev && rst) width_q.push_back(en_len);
            en_len <= 0;
        end
        if (!o_busy && busy_prev) fall_cyc <= cyc;
        en_prev   <= LCD_EN;
        busy_prev <= o_busy;
    end

    int         total = 0;
    int         bad   = 0;
    int         rd    = 0;
    int         wrd   = 0;
    logic [6:0] shown = 7'd0;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] v);
        {i_state, i_play_speed} = v;
    endtask

    function automatic string pad16(input string s);
        string r;
        r = s;
        while (r.len() < 16) r = {r, " "};
        return r;
    endfunction

    function automatic bit model_init(input logic [2:0] st);
        return (st == 3'b101) || (st == 3'b001);
    endfunction

    function automatic string line1_model(input logic [2:0] st);
        if (model_init(st)) return pad16("MODE: INIT");
        if (int'(st) < 4) return pad16("MODE: PLAY");
        return pad16("MODE: RECORD");
    endfunction

    function automatic string speed_model(input logic [3:0] sp);
        int v;
        v = int'(sp);
        if (v == 0) return "x1";
        if (v == 8) return "x?";
        if (v > 8) return $sformatf("x%0d", v - 7);
        return $sformatf("x1/%0d", v + 1);
    endfunction

    function automatic string line2_model(input logic [2:0] st, input logic [3:0] sp);
        string w;
        string s;
        if (model_init(st)) begin
            w = "-----";
        end else begin
            case (int'(st))
                0, 4:    w = "STOP ";
                2:       w = "PLAY ";
                6:       w = "REC  ";
                default: w = "PAUSE";
            endcase
        end
        s = (model_init(st) || int'(st) >= 4) ? "--" : speed_model(sp);
        return pad16({w, " SPD: ", s});
    endfunction

    task automatic wait_bytes(input int n, output bit ok);
        int t;
        t = 0;
        while (byte_q.size() < rd + n && t < 3000) begin
            step();
            t++;
        end
        ok = (byte_q.size() >= rd + n);
        if (!ok) check_val("byte_timeout", byte_q.size() - rd, n);
    endtask

    task automatic check_widths();
        while (wrd < width_q.size()) begin
            check_val("en_width", width_q[wrd], TEn);
            wrd++;
        end
    endtask

    task automatic check_refresh(input logic [6:0] v, input string tag);
        bit    ok;
        string l1;
        string l2;
        l1 = line1_model(v[6:4]);
        l2 = line2_model(v[6:4], v[3:0]);
        wait_bytes(34, ok);
        if (!ok) return;
        check_val({tag, ":cmd80"}, int'(byte_q[rd]), 'h080);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("%s:l1[%0d]", tag, i), int'(byte_q[rd + 1 + i]),
                      int'({1'b1, l1[i]}));
        check_val({tag, ":cmdC0"}, int'(byte_q[rd + 17]), 'h0C0);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("%s:l2[%0d]", tag, i), int'(byte_q[rd + 18 + i]),
                      int'({1'b1, l2[i]}));
        for (int i = 1; i < 34; i++)
            check_val($sformatf("%s:gap%0d", tag, i), rise_q[rd + i] - rise_q[rd + i - 1],
                      ByteGap);
        rd += 34;
        shown = v;
        check_widths();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_busy && t < 3000) begin
            step();
            t++;
        end
        check_val("idle_reached", int'(o_busy), 0);
    endtask

    task automatic check_quiet(input string tag);
        repeat (20) step();
        check_val({tag, ":no_bytes"}, byte_q.size() - rd, 0);
        check_val({tag, ":busy"}, int'(o_busy), 0);
    endtask

    // Called with rst low for at least one edge; releases reset and checks bring-up.
    task automatic reset_and_init(input string tag);
        logic [7:0] init_cmd[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int         rel;
        int         last_init;
        bit         ok;
        check_val({tag, ":rst_en"}, int'(LCD_EN), 0);
        check_val({tag, ":rst_rs"}, int'(LCD_RS), 0);
        check_val({tag, ":rst_data"}, int'(LCD_DATA), 0);
        check_val({tag, ":rst_busy"}, int'(o_busy), 1);
        check_val({tag, ":rw_on_blon"}, int'({LCD_RW, LCD_ON, LCD_BLON}), 3);
        rd  = byte_q.size();
        wrd = width_q.size();
        rel = cyc;
        rst = 1'b1;
        wait_bytes(4, ok);
        if (!ok) return;
        check_val({tag, ":pwrup_delay"}, rise_q[rd] - rel, TPwrup + 1);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("%s:init%0d", tag, k), int'(byte_q[rd + k]),
                      int'({1'b0, init_cmd[k]}));
        for (int k = 1; k < 4; k++)
            check_val($sformatf("%s:init_gap%0d", tag, k), rise_q[rd + k] - rise_q[rd + k - 1],
                      (k == 3) ? ClrGap : ByteGap);
        last_init = rise_q[rd + 3];
        rd += 4;
        check_refresh({i_state, i_play_speed}, {tag, ":scr"});
        if (rise_q.size() >= rd)
            check_val({tag, ":init_to_ref"}, rise_q[rd - 34] - last_init, ByteGap);
        wait_idle();
        check_val({tag, ":busy_fall"}, fall_cyc - rise_q[rd - 1], TEn + TCmd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] v1;
        logic [6:0] v2;
        int         t;
        rst = 1'b0;
        set_in(7'b101_0000);
        repeat (3) step();
        reset_and_init("boot");
        check_quiet("idle0");

        set_in(7'b010_1011);
        step();
        check_val("busy_rise", int'(o_busy), 1);
        check_refresh(7'b010_1011, "play_x4");
        wait_idle();

        set_in(7'b010_0000);
        repeat (40) step();
        set_in(7'b010_0111);
        repeat (40) step();
        set_in(7'b010_0001);
        check_refresh(7'b010_0000, "mid_first");
        check_refresh(7'b010_0001, "mid_latest");
        wait_idle();
        check_quiet("mid_quiet");

        set_in(7'b110_1111);
        check_refresh(7'b110_1111, "rec");
        wait_idle();

        for (int it = 0; it < 10; it++) begin
            v1 = 7'($urandom_range(0, 127));
            set_in(v1);
            if (v1 == shown) begin
                check_quiet("rnd_same");
            end else begin
                v2 = v1;
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(2, 200)) step();
                    v2 = 7'($urandom_range(0, 127));
                    set_in(v2);
                end
                check_refresh(v1, $sformatf("rnd%0d", it));
                if (v2 != v1) check_refresh(v2, $sformatf("rnd%0d_late", it));
                wait_idle();
                check_quiet("rnd_quiet");
            end
        end

        set_in((shown == 7'b011_1001) ? 7'b000_0101 : 7'b011_1001);
        repeat ($urandom_range(0, 100)) step();
        t = 0;
        while (!LCD_EN && t < 100) begin
            step();
            t++;
        end
        check_val("pulse_found", int'(LCD_EN), 1);
        rst = 1'b0;
        step();
        reset_and_init("rst_mid");

        check_widths();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
